// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// The master is the pipeline side and the slave is the ex_muldiv unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd;
  logic            stall;
  logic            kill;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd, stall, kill,
    input  stall_req, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd, stall, kill,
    output stall_req, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic [2*XLEN-1:0]   acc;
  logic                neg_q;
  logic                neg_r;
  logic                done_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          rd_q;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand decode for the accept cycle
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;

  always_comb begin
    a_sgn    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    b_sgn    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    a_neg    = a_sgn & bus.rs1_data[XLEN-1];
    b_neg    = b_sgn & bus.rs2_data[XLEN-1];
    a_abs    = neg_if(bus.rs1_data, a_neg);
    b_abs    = neg_if(bus.rs2_data, b_neg);
    is_div   = bus.op[2];
    div_zero = is_div && (bus.rs2_data == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.rs2_data == '1);
    fast_res = '1;
    if (div_zero)
      fast_res = bus.op[1] ? bus.rs1_data : '1;
    else if (div_ovf)
      fast_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration step for each engine, plus the sign-corrected final results
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fin, div_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_new;
  logic              qbit;
  logic [XLEN-1:0]   mul_res, div_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    prod_fin = neg_if_wide(mul_next, neg_q);
    mul_res  = (op_q == 3'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

    // The difference fits in XLEN bits whenever the trial subtract succeeds.
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    qbit     = (rem_sh >= {1'b0, b_mag});
    rem_new  = qbit ? (rem_sh[XLEN-1:0] - b_mag) : rem_sh[XLEN-1:0];
    div_next = {rem_new, acc[XLEN-2:0], qbit};
    div_res  = op_q[1] ? neg_if(div_next[2*XLEN-1:XLEN], neg_r)
                       : neg_if(div_next[XLEN-1:0], neg_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.kill) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd;
            cnt   <= '0;
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc   <= is_div ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
            if (div_zero || div_ovf) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= is_div ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (bus.kill) begin
            state <= S_IDLE;
          end else begin
            acc <= (state == S_MUL) ? mul_next : div_next;
            if (cnt == CNT_W'(XLEN-1)) begin
              result_q <= (state == S_MUL) ? mul_res : div_res;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (bus.kill || !bus.stall) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_req = !bus.kill &&
                         (((state == S_IDLE) && bus.start) || (state == S_MUL) || (state == S_DIV));
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.rd_out    = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes reference results, a monitor
// pops and compares on each rising done.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();
  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // Reference model: plain 64-bit arithmetic following RV32M semantics.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare once per done pulse against the oldest expectation.
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.done === 1'b1 && !prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got result %h, expected no done", bus.result);
          end else begin
            e = exp_q.pop_front();
            check("result", bus.result, e.res);
            check("rd_out", 32'(bus.rd_out), 32'(e.rd));
          end
        end
        prev = (bus.done === 1'b1);
      end
    end
  end

  task automatic wait_done(output int cyc, output bit sreq_bad, input bit poke);
    cyc = 1;
    sreq_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        bus.start = 1'b0;
        break;
      end
      if (bus.stall_req !== 1'b1) sreq_bad = 1'b1;
      if (poke) begin
        bus.start    = 1'($urandom);
        bus.op       = 3'($urandom);
        bus.rs1_data = $urandom;
      end
      cyc++;
      if (cyc > 100) break;
    end
  endtask

  // Called just after a rising edge; returns just after the edge following done.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rdv);
    int cyc;
    bit sreq_bad;
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd = rdv;
    exp_q.push_back('{ref_model(op, a, b), rdv});
    @(negedge clk);
    check("stall_req_accept", 32'(bus.stall_req), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs1_data = $urandom; bus.rs2_data = $urandom; bus.rd = 5'($urandom);
    wait_done(cyc, sreq_bad, 1'b1);
    check("latency", 32'(cyc), is_fast(op, a, b) ? 32'd1 : 32'd33);
    check("stall_req_busy", 32'(sreq_bad), 32'd0);
    check("stall_req_done", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  cyc;
    bit  sreq_bad;
    bit  seen;

    bus.start = 0; bus.op = 0; bus.rs1_data = 0; bus.rs2_data = 0; bus.rd = 0;
    bus.stall = 0; bus.kill = 0;
    #3 rst = 1'b1;
    #1;
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_rd_out", 32'(bus.rd_out), 32'd0);
    check("reset_stall_req", 32'(bus.stall_req), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed operations from the test plan
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    do_op(3'd5, 32'd100, 32'd7, 5'd6);
    do_op(3'd7, 32'd100, 32'd7, 5'd7);
    do_op(3'd4, 32'd5, 32'd0, 5'd8);
    do_op(3'd7, 32'h1234, 32'd0, 5'd9);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // Hold the result with stall for three cycles; a start during DONE is ignored
    bus.stall = 1'b1;
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd7; bus.rs2_data = 32'hFFFF_FFFD; bus.rd = 5'd20;
    exp_q.push_back('{32'hFFFF_FFEB, 5'd20});
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(cyc, sreq_bad, 1'b0);
    check("stall_latency", 32'(cyc), 32'd33);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd = 5'd21;
      end
      if (k == 2) bus.start = 1'b0;
      if (k == 3) bus.stall = 1'b0;
      @(negedge clk);
      check("stall_hold_done", 32'(bus.done), 32'd1);
      check("stall_hold_result", bus.result, 32'hFFFF_FFEB);
      check("stall_hold_rd", 32'(bus.rd_out), 32'd20);
    end
    @(posedge clk); #1;
    do_op(3'd5, 32'd100, 32'd7, 5'd22);

    // kill at cycle 10 of a divide, then kill blocking an IDLE start
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1_data = 32'h1234_5678; bus.rs2_data = 32'd3; bus.rd = 5'd23;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(negedge clk);
    check("kill_stall_req", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd0;
    @(negedge clk);
    check("kill_idle_stall_req", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1 bus.kill = 1'b0; bus.start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.stall_req !== 1'b0) seen = 1'b1;
    end
    check("kill_no_done", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a multiply
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.rd = 5'd24;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    check("rst_mid_rd_out", 32'(bus.rd_out), 32'd0);
    check("rst_mid_stall_req", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_op(3'd0, 32'h0001_0003, 32'h0000_0101, 5'd25);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      do_op(3'($urandom), pick(), pick(), 5'($urandom));

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks passed %0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
